// File: rtl/rom_load_ctrl.sv
// ROM image download sequencer: routes HPS ioctl bytes through a 4-entry write FIFO onto the
// shared ROM write port, captures module/DIP bytes and holds the board cores until settled.
module rom_load_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_wr_valid,
    input  logic        rom_wr_ready,
    output logic [1:0]  rom_wr_region,
    output logic [15:0] rom_wr_addr,
    output logic [7:0]  rom_wr_data,
    output logic [7:0]  mod,
    output logic [63:0] dip_sw,
    output logic        core_hold,
    output logic        err_overflow
);

    typedef enum logic [2:0] {StWaitRom, StLoading, StDrain, StSettle, StRun} state_e;

    state_e       state_q;
    logic [15:0]  settle_q;
    logic         hold_q;
    logic [25:0]  mem_q [4];
    logic [1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0]   count_q, count_d;
    logic         wait_q, err_q;
    logic [7:0]   mod_q;
    logic [63:0]  dip_q;

    logic         dec_valid;
    logic [1:0]   dec_region;
    logic [15:0]  dec_rel;
    logic         push_req, push, pop, full, dl_rom;

    // Region offsets all sit on 4 KiB boundaries, so 16-bit modular subtraction suffices.
    always_comb begin
        dec_valid  = 1'b1;
        dec_region = 2'd0;
        dec_rel    = ioctl_addr[15:0];
        if (ioctl_addr < 25'h10000) begin
            dec_region = 2'd0;
        end else if (ioctl_addr < 25'h11000) begin
            dec_region = 2'd1;
        end else if (ioctl_addr < 25'h13000) begin
            dec_region = 2'd2;
            dec_rel    = ioctl_addr[15:0] - 16'h1000;
        end else if (ioctl_addr < 25'h1B000) begin
            dec_region = 2'd3;
            dec_rel    = ioctl_addr[15:0] - 16'h3000;
        end else begin
            dec_valid  = 1'b0;
        end
    end

    assign dl_rom   = ioctl_download & (ioctl_index == 8'd0);
    assign push_req = ioctl_wr & dl_rom & dec_valid;
    assign full     = (count_q == 3'(FIFO_DEPTH));
    assign pop      = (count_q != 3'd0) & rom_wr_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
    assign push     = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dec_region, dec_rel, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            wait_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
            wait_q  <= (count_d >= 3'd3);
            if (push_req && !push) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mod_q <= 8'hFF;
            dip_q <= 64'd0;
        end else if (ioctl_wr) begin
            if (ioctl_index == 8'd1) mod_q <= ioctl_dout;
            if (ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0) begin
                dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StWaitRom;
            settle_q <= 16'd0;
            hold_q   <= 1'b1;
        end else begin
            case (state_q)
                StWaitRom: if (dl_rom) state_q <= StLoading;
                StLoading: if (!ioctl_download) state_q <= StDrain;
                StDrain: begin
                    if (count_q == 3'd0) begin
                        state_q  <= StSettle;
                        settle_q <= 16'(SETTLE_CYCLES - 1);
                    end
                end
                StSettle: begin
                    if (dl_rom) begin
                        state_q <= StLoading;
                    end else if (settle_q == 16'd0) begin
                        state_q <= StRun;
                        hold_q  <= 1'b0;
                    end else begin
                        settle_q <= settle_q - 16'd1;
                    end
                end
                StRun: begin
                    if (dl_rom) begin
                        state_q <= StLoading;
                        hold_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StWaitRom;
                    hold_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rom_wr_valid  = (count_q != 3'd0);
    assign rom_wr_region = mem_q[rd_ptr_q][25:24];
    assign rom_wr_addr   = mem_q[rd_ptr_q][23:8];
    assign rom_wr_data   = mem_q[rd_ptr_q][7:0];
    assign ioctl_wait    = wait_q;
    assign err_overflow  = err_q;
    assign mod           = mod_q;
    assign dip_sw        = dip_q;
    assign core_hold     = hold_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: expected ROM writes are queued when bytes are driven
// and compared as the DUT retires them.
module tb_rom_load_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_wr_valid;
    logic        rom_wr_ready;
    logic [1:0]  rom_wr_region;
    logic [15:0] rom_wr_addr;
    logic [7:0]  rom_wr_data;
    logic [7:0]  mod;
    logic [63:0] dip_sw;
    logic        core_hold;
    logic        err_overflow;

    int checks   = 0;
    int failures = 0;
    logic [25:0] sb [$];

    rom_load_ctrl #(.SETTLE_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .rom_wr_valid  (rom_wr_valid),
        .rom_wr_ready  (rom_wr_ready),
        .rom_wr_region (rom_wr_region),
        .rom_wr_addr   (rom_wr_addr),
        .rom_wr_data   (rom_wr_data),
        .mod           (mod),
        .dip_sw        (dip_sw),
        .core_hold     (core_hold),
        .err_overflow  (err_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode: bit 26 flags a byte that lands in a ROM region.
    function automatic logic [26:0] model_entry(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] base;
        logic [1:0]  rg;
        logic [24:0] rel;
        if (a <= 25'h0FFFF)      begin base = 25'h00000; rg = 2'd0; end
        else if (a <= 25'h10FFF) begin base = 25'h10000; rg = 2'd1; end
        else if (a <= 25'h12FFF) begin base = 25'h11000; rg = 2'd2; end
        else if (a <= 25'h1AFFF) begin base = 25'h13000; rg = 2'd3; end
        else return 27'd0;
        rel = a - base;
        return {1'b1, rg, rel[15:0], d};
    endfunction

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one strobe for a cycle; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                        input bit dropped);
        logic [26:0] e;
        e = model_entry(a, d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (idx == 8'd0 && ioctl_download && e[26] && !dropped) sb.push_back(e[25:0]);
        next_cycle();
        ioctl_wr = 1'b0;
    endtask

    task automatic cycles_to_release(output int n);
        n = 0;
        while (core_hold && n < 200) begin
            next_cycle();
            n++;
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && rom_wr_valid && rom_wr_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 64'(rom_wr_valid), 64'd0);
            end else begin
                check_eq("rom_write", 64'({rom_wr_region, rom_wr_addr, rom_wr_data}),
                         64'(sb.pop_front()));
            end
        end
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        rom_wr_ready   = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        @(negedge clk_sys);
        check_eq("rst_hold", 64'(core_hold), 64'd1);
        check_eq("rst_mod", 64'(mod), 64'hFF);
        check_eq("rst_dip", dip_sw, 64'd0);
        check_eq("rst_valid", 64'(rom_wr_valid), 64'd0);
        check_eq("rst_wait", 64'(ioctl_wait), 64'd0);
        check_eq("rst_err", 64'(err_overflow), 64'd0);

        // Streaming burst across the region 2/3 boundary, plus one out-of-map byte.
        next_cycle();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        rom_wr_ready   = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd0, 25'h12FFE + 25'(i), 8'h10 + 8'(i), 1'b0);
        send(8'd0, 25'h1B000, 8'hEE, 1'b0);
        repeat (3) next_cycle();
        check_eq("burst_retired", 64'(sb.size()), 64'd0);
        check_eq("burst_hold", 64'(core_hold), 64'd1);
        check_eq("burst_err", 64'(err_overflow), 64'd0);

        // Fill with the port stalled, then push+pop at full, then overflow.
        rom_wr_ready = 1'b0;
        send(8'd0, 25'h00100, 8'hA1, 1'b0);
        send(8'd0, 25'h00101, 8'hA2, 1'b0);
        @(negedge clk_sys);
        check_eq("wait_at_2", 64'(ioctl_wait), 64'd0);
        next_cycle();
        send(8'd0, 25'h00102, 8'hA3, 1'b0);
        @(negedge clk_sys);
        check_eq("wait_at_3", 64'(ioctl_wait), 64'd1);
        next_cycle();
        send(8'd0, 25'h00103, 8'hA4, 1'b0);
        rom_wr_ready = 1'b1;
        send(8'd0, 25'h0FFFF, 8'hA5, 1'b0);
        rom_wr_ready = 1'b0;
        @(negedge clk_sys);
        check_eq("full_pushpop_err", 64'(err_overflow), 64'd0);
        check_eq("full_pushpop_wait", 64'(ioctl_wait), 64'd1);
        next_cycle();
        send(8'd0, 25'h00104, 8'hA6, 1'b1);
        @(negedge clk_sys);
        check_eq("overflow_err", 64'(err_overflow), 64'd1);
        next_cycle();
        rom_wr_ready = 1'b1;
        repeat (6) next_cycle();
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
        check_eq("drain_wait", 64'(ioctl_wait), 64'd0);
        check_eq("err_sticky", 64'(err_overflow), 64'd1);

        // Download ends with two entries queued.
        rom_wr_ready = 1'b0;
        send(8'd0, 25'h10000, 8'hB0, 1'b0);
        send(8'd0, 25'h10001, 8'hB1, 1'b0);
        ioctl_download = 1'b0;
        rom_wr_ready   = 1'b1;
        cycles_to_release(n);
        check_eq("release_latency", 64'(n), 64'd19);
        check_eq("release_empty", 64'(sb.size()), 64'd0);

        // New download from RUN, then re-entry from SETTLE.
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_eq("hold_same_cycle", 64'(core_hold), 64'd0);
        next_cycle();
        check_eq("hold_rises", 64'(core_hold), 64'd1);
        ioctl_download = 1'b0;
        repeat (7) next_cycle();
        ioctl_download = 1'b1;
        repeat (2) next_cycle();
        check_eq("settle_reenter_hold", 64'(core_hold), 64'd1);
        ioctl_download = 1'b0;
        cycles_to_release(n);
        check_eq("rerelease_latency", 64'(n), 64'd18);

        // DIP and module bytes in RUN.
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        send(8'd254, 25'd3, 8'h5A, 1'b0);
        @(negedge clk_sys);
        check_eq("dip_byte3", dip_sw, 64'h0000_0000_5A00_0000);
        check_eq("dip_hold", 64'(core_hold), 64'd0);
        next_cycle();
        send(8'd254, 25'd8, 8'h77, 1'b0);
        @(negedge clk_sys);
        check_eq("dip_out_of_range", dip_sw, 64'h0000_0000_5A00_0000);
        next_cycle();
        ioctl_index = 8'd1;
        send(8'd1, 25'd0, 8'h04, 1'b0);
        @(negedge clk_sys);
        check_eq("mod_load", 64'(mod), 64'h04);
        check_eq("mod_hold", 64'(core_hold), 64'd0);
        next_cycle();
        ioctl_download = 1'b0;
        repeat (3) next_cycle();
        check_eq("final_hold", 64'(core_hold), 64'd0);
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("final_valid", 64'(rom_wr_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
